// File: rtl/adc_seq_ctrl.sv
// adc_seq_ctrl: conversion sequencer for the SAR ADC. Issues GO pulses, captures results,
// accumulates bursts of NSAMP+1 samples, with continuous mode, inter-conversion gap and VALID watchdog.
module adc_seq_ctrl #(
   parameter int RES_W  = 5,
   parameter int NS_W   = 5,
   parameter int TO_CYC = 255
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  START,
   input  logic                  ABORT,
   input  logic                  CONT,
   input  logic [NS_W-1:0]       NSAMP,
   input  logic [7:0]            INTERVAL,
   output logic                  ADC_GO,
   input  logic                  ADC_VALID,
   input  logic [RES_W-1:0]      ADC_RESULT,
   output logic [RES_W-1:0]      LAST,
   output logic [RES_W+NS_W-1:0] SUM,
   output logic [NS_W:0]         CNT,
   output logic                  BUSY,
   output logic                  DONE,
   output logic                  TOUT
);

   localparam int AW = RES_W + NS_W;
   localparam int TW = $clog2(TO_CYC + 1);

   typedef enum logic [1:0] {IDLE, GO, WAIT, GAP} state_t;

   state_t          r_state;
   state_t          w_nextState;
   logic [AW-1:0]   r_acc;
   logic [TW-1:0]   r_timer;
   logic [7:0]      r_gap;
   logic [AW-1:0]   w_sum;
   logic [NS_W:0]   w_cntInc;
   logic [NS_W:0]   w_target;
   logic            w_start;
   logic            w_accept;
   logic            w_complete;
   logic            w_timeout;

   always_comb begin
      w_sum       = r_acc + AW'(ADC_RESULT);
      w_cntInc    = CNT + (NS_W+1)'(1);
      w_target    = {1'b0, NSAMP} + (NS_W+1)'(1);
      w_start     = (r_state == IDLE) && START && !ABORT;
      w_accept    = (r_state == WAIT) && ADC_VALID && !ABORT;
      // NSAMP is compared live; >= keeps a shrunk NSAMP from running the burst past its end
      w_complete  = w_accept && (w_cntInc >= w_target);
      // Timer reaches TO_CYC-1 on this edge; a coincident VALID takes priority
      w_timeout   = (r_state == WAIT) && !ADC_VALID && !ABORT && (r_timer == TW'(TO_CYC - 2));
      w_nextState = r_state;
      if (ABORT) begin
         w_nextState = IDLE;
      end else begin
         case (r_state)
            IDLE: if (START) w_nextState = GO;
            GO:   w_nextState = WAIT;
            WAIT: begin
               if (w_accept) begin
                  if (w_complete && !CONT) w_nextState = IDLE;
                  else if (INTERVAL == 8'd0) w_nextState = GO;
                  else w_nextState = GAP;
               end else if (w_timeout) begin
                  w_nextState = IDLE;
               end
            end
            GAP:  if (r_gap == 8'd0) w_nextState = GO;
            default: w_nextState = IDLE;
         endcase
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         ADC_GO  <= 1'b0;
         BUSY    <= 1'b0;
         DONE    <= 1'b0;
         TOUT    <= 1'b0;
         LAST    <= '0;
         SUM     <= '0;
         CNT     <= '0;
         r_acc   <= '0;
         r_timer <= '0;
         r_gap   <= '0;
      end else begin
         ADC_GO <= (w_nextState == GO);
         BUSY   <= (w_nextState != IDLE);
         DONE   <= w_complete;
         if (w_start) begin
            r_acc <= '0;
            CNT   <= '0;
            TOUT  <= 1'b0;
         end
         if (w_timeout) begin
            TOUT <= 1'b1;
         end
         if (w_accept) begin
            LAST <= ADC_RESULT;
            if (w_complete) begin
               SUM <= w_sum;
            end
            if (w_complete && CONT) begin
               r_acc <= '0;
               CNT   <= '0;
            end else begin
               r_acc <= w_sum;
               CNT   <= w_cntInc;
            end
         end
         r_timer <= (r_state == WAIT) ? r_timer + TW'(1) : '0;
         // INTERVAL is latched only on GAP entry, then counted down to zero
         if ((r_state == WAIT) && (w_nextState == GAP)) begin
            r_gap <= INTERVAL;
         end else if ((r_state == GAP) && (r_gap != 8'd0)) begin
            r_gap <= r_gap - 8'd1;
         end
      end
   end

endmodule
